serial_packet_arbiter: RTL and testbench

- Shares one UART byte transmitter (async_transmitter style: start pulse, 8-bit data, busy) among NUM_REQ packet sources, e.g. several counter/event reporters.
- Each source offers one packet: 8-bit header plus 32-bit payload.
- The arbiter grants round-robin, latches the packet, and serialises it as header then payload bytes LSB-first.
- Sits between the packet producers and the single TxD line.

---
 rtl/pvs_serial_pkg.sv | 31 +++
 rtl/serial_packet_arbiter_rr.sv | 24 ++
 rtl/serial_packet_arbiter.sv | 161 ++++++++++++++++
 tb/tb_serial_packet_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pvs_serial_pkg.sv
// rtl/pvs_serial_pkg.sv - shared types, widths and round-robin pick helper for the packet arbiter
package pvs_serial_pkg;

  localparam int HEADER_W  = 8;
  localparam int PAYLOAD_W = 32;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_ACCEPT = 3'd2,
    S_DRAIN  = 3'd3,
    S_NEXT   = 3'd4
  } state_t;

  // Returns {valid, index}: the first set request at or after ptr, wrapping modulo n (n <= 8).
  // Offsets are scanned from the far end down so the nearest requester wins.
  function automatic logic [3:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
    logic [3:0] res;
    logic [3:0] idx;
    res = 4'd0;
    for (int k = 7; k >= 0; k--) begin
      if (k < n) begin
        idx = {1'b0, ptr} + 4'(k);
        if (idx >= 4'(n)) idx = idx - 4'(n);
        if (req[idx[2:0]]) res = {1'b1, idx[2:0]};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/serial_packet_arbiter_rr.sv
// rtl/serial_packet_arbiter_rr.sv - combinational round-robin grant selection
module rr_arbiter
  import pvs_serial_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic               o_grant_valid,
  output logic [2:0]         o_grant_idx
);

  logic [7:0] w_req8;
  logic [2:0] w_ptr3;
  logic [3:0] w_pick;

  assign w_req8        = 8'(i_req);
  assign w_ptr3        = 3'(i_ptr);
  assign w_pick        = rr_pick(w_req8, w_ptr3, NUM_REQ);
  assign o_grant_valid = w_pick[3];
  assign o_grant_idx   = w_pick[2:0];

endmodule

// File: rtl/serial_packet_arbiter.sv
// rtl/serial_packet_arbiter.sv - round-robin packet arbiter serialising header+payload onto one UART transmitter
module serial_packet_arbiter
  import pvs_serial_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int PAYLOAD_BYTES  = 4,
  parameter int ACCEPT_TIMEOUT = 15
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [HEADER_W*NUM_REQ-1:0]  header_in,
  input  logic [PAYLOAD_W*NUM_REQ-1:0] payload_in,
  output logic [NUM_REQ-1:0]           ack,
  output logic [NUM_REQ-1:0]           done,
  output logic                         tx_start,
  output logic [7:0]                   tx_data,
  input  logic                         tx_busy,
  output logic                         busy,
  output logic [2:0]                   grant_id,
  output logic                         err_noaccept
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int BW    = $clog2(PAYLOAD_BYTES + 1);
  localparam int CW    = $clog2(ACCEPT_TIMEOUT + 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [PTR_W-1:0]     r_rr_ptr;
  logic [HEADER_W-1:0]  r_hdr;
  logic [PAYLOAD_W-1:0] r_buf;
  logic [BW-1:0]        r_byte_idx;
  logic [CW-1:0]        r_acc_cnt;
  logic [NUM_REQ-1:0]   r_ack;
  logic [NUM_REQ-1:0]   r_done;
  logic                 r_tx_start;
  logic [7:0]           r_tx_data;
  logic                 r_busy;
  logic [2:0]           r_grant_id;
  logic                 r_err;

  logic                 w_grant_valid;
  logic [2:0]           w_grant_idx;
  logic                 w_grant;
  logic                 w_last;
  logic                 w_timeout;
  logic [PTR_W-1:0]     w_ptr_nxt;
  logic [NUM_REQ-1:0]   w_one;
  logic [7:0]           w_pay_byte;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .i_req         (req),
    .i_ptr         (r_rr_ptr),
    .o_grant_valid (w_grant_valid),
    .o_grant_idx   (w_grant_idx)
  );

  // A foreign or still-draining transmission blocks new grants.
  assign w_grant   = w_grant_valid && !tx_busy;
  assign w_last    = (r_byte_idx == BW'(PAYLOAD_BYTES));
  assign w_timeout = (r_acc_cnt == CW'(ACCEPT_TIMEOUT - 1));
  assign w_ptr_nxt = (w_grant_idx == 3'(NUM_REQ - 1)) ? '0 : PTR_W'(w_grant_idx + 3'd1);
  assign w_one     = NUM_REQ'(1);

  // Payload byte for the current index; byte_idx 1 is the payload LSB.
  always_comb begin
    w_pay_byte = 8'h00;
    for (int b = 0; b < PAYLOAD_BYTES; b++) begin
      if (r_byte_idx == BW'(b + 1)) w_pay_byte = r_buf[8*b +: 8];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic for the per-byte handshake with the transmitter.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_grant) w_state_nxt = S_START;
      S_START:  w_state_nxt = S_ACCEPT;
      S_ACCEPT: begin
        if (tx_busy)        w_state_nxt = S_DRAIN;
        else if (w_timeout) w_state_nxt = S_NEXT;
      end
      S_DRAIN:  if (!tx_busy) w_state_nxt = S_NEXT;
      S_NEXT:   w_state_nxt = w_last ? S_IDLE : S_START;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Registered datapath and outputs: grant latch, byte issue, accept watchdog, completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr   <= '0;
      r_hdr      <= '0;
      r_buf      <= '0;
      r_byte_idx <= '0;
      r_acc_cnt  <= '0;
      r_ack      <= '0;
      r_done     <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
      r_busy     <= 1'b0;
      r_grant_id <= 3'd0;
      r_err      <= 1'b0;
    end else begin
      r_ack      <= '0;
      r_done     <= '0;
      r_tx_start <= 1'b0;
      r_busy     <= (w_state_nxt != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_hdr      <= header_in[HEADER_W*w_grant_idx +: HEADER_W];
            r_buf      <= payload_in[PAYLOAD_W*w_grant_idx +: PAYLOAD_W];
            r_grant_id <= w_grant_idx;
            r_ack      <= w_one << w_grant_idx;
            r_rr_ptr   <= w_ptr_nxt;
          end
        end
        S_START: begin
          r_tx_start <= 1'b1;
          r_tx_data  <= (r_byte_idx == '0) ? r_hdr : w_pay_byte;
          r_acc_cnt  <= '0;
        end
        S_ACCEPT: begin
          if (!tx_busy) begin
            if (w_timeout) r_err     <= 1'b1;
            else           r_acc_cnt <= r_acc_cnt + CW'(1);
          end
        end
        S_NEXT: begin
          if (w_last) begin
            r_done     <= w_one << r_grant_id;
            r_byte_idx <= '0;
          end else begin
            r_byte_idx <= r_byte_idx + BW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign ack          = r_ack;
  assign done         = r_done;
  assign tx_start     = r_tx_start;
  assign tx_data      = r_tx_data;
  assign busy         = r_busy;
  assign grant_id     = r_grant_id;
  assign err_noaccept = r_err;

endmodule

// File: tb/tb_serial_packet_arbiter.sv
// tb/tb_serial_packet_arbiter.sv - directed self-checking bench for serial_packet_arbiter
module tb_serial_packet_arbiter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req = 4'd0;
  logic [31:0]  header_in = 32'd0;
  logic [127:0] payload_in = 128'd0;
  logic [3:0]   ack;
  logic [3:0]   done;
  logic         tx_start;
  logic [7:0]   tx_data;
  logic         tx_busy;
  logic         busy;
  logic [2:0]   grant_id;
  logic         err_noaccept;

  int vec = 0;
  int miss = 0;

  serial_packet_arbiter #(
    .NUM_REQ        (4),
    .PAYLOAD_BYTES  (4),
    .ACCEPT_TIMEOUT (15)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .header_in    (header_in),
    .payload_in   (payload_in),
    .ack          (ack),
    .done         (done),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_busy      (tx_busy),
    .busy         (busy),
    .grant_id     (grant_id),
    .err_noaccept (err_noaccept)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy for 10 cycles after tx_start; unaffected by rst_n.
  int   bcnt = 0;
  logic busy_dis = 1'b0;
  logic ext_busy = 1'b0;
  always @(posedge clk) begin
    if (tx_start && !busy_dis) bcnt <= 10;
    else if (bcnt > 0)         bcnt <= bcnt - 1;
  end
  assign tx_busy = (bcnt != 0) || ext_busy;

  // Monitor: byte stream, grant/done order and event cycles.
  int         cyc = 0;
  logic [7:0] txq[$];
  int         ackq[$];
  int         doneq[$];
  int         overlap = 0;
  int         first_start = -1;
  int         err_cyc = -1;
  int         ack_cyc = 0;
  int         done_cyc = 0;
  int         fall_cyc = 0;
  logic       prev_busy = 1'b0;

  function automatic int idx_of(input logic [3:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (v[i]) r = (r < 0) ? i : 9;
    return r;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (tx_start) begin
      txq.push_back(tx_data);
      if (tx_busy) overlap++;
      if (first_start < 0) first_start = cyc;
    end
    if (ack != 4'd0) begin
      ackq.push_back(idx_of(ack));
      ack_cyc = cyc;
    end
    if (done != 4'd0) begin
      doneq.push_back(idx_of(done));
      done_cyc = cyc;
    end
    if (prev_busy && !tx_busy) fall_cyc = cyc;
    if (err_noaccept && err_cyc < 0) err_cyc = cyc;
    prev_busy = tx_busy;
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon;
    txq.delete();
    ackq.delete();
    doneq.delete();
    overlap = 0;
    first_start = -1;
    err_cyc = -1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req = 4'd0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_done(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (doneq.size() < n && k < budget) begin
      tick();
      k++;
    end
    ok = (doneq.size() >= n);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    vec++; if (ack !== 4'd0)       begin miss++; $display("FAIL reset_ack: got %h want 0", ack); end
    vec++; if (done !== 4'd0)      begin miss++; $display("FAIL reset_done: got %h want 0", done); end
    vec++; if (tx_start !== 1'b0)  begin miss++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
    vec++; if (tx_data !== 8'h00)  begin miss++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    vec++; if (busy !== 1'b0)      begin miss++; $display("FAIL reset_busy: got %b want 0", busy); end
    vec++; if (grant_id !== 3'd0)  begin miss++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
    vec++; if (err_noaccept !== 1'b0) begin miss++; $display("FAIL reset_err: got %b want 0", err_noaccept); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single;
    logic [7:0] exp_b [5];
    bit ok;
    exp_b[0] = 8'hA5; exp_b[1] = 8'h44; exp_b[2] = 8'h33; exp_b[3] = 8'h22; exp_b[4] = 8'h11;
    clear_mon();
    header_in[15:8]   = 8'hA5;
    payload_in[63:32] = 32'h11223344;
    req = 4'b0010;
    tick();
    vec++; if (ack !== 4'b0010) begin miss++; $display("FAIL single_ack: got %b want 0010", ack); end
    req = 4'd0;
    wait_done(1, 300, ok);
    vec++; if (!ok) begin miss++; $display("FAIL single_done_timeout: got %0d dones want 1", doneq.size()); end
    vec++; if (txq.size() != 5) begin miss++; $display("FAIL single_nbytes: got %0d want 5", txq.size()); end
    for (int i = 0; i < 5; i++) begin
      if (i < txq.size()) begin
        vec++; if (txq[i] !== exp_b[i]) begin miss++; $display("FAIL single_byte%0d: got %h want %h", i, txq[i], exp_b[i]); end
      end
    end
    vec++; if (first_start - ack_cyc != 1) begin miss++; $display("FAIL single_start_lat: got %0d want 1", first_start - ack_cyc); end
    vec++; if (done_cyc - fall_cyc != 2) begin miss++; $display("FAIL single_done_lat: got %0d want 2", done_cyc - fall_cyc); end
    if (doneq.size() > 0) begin
      vec++; if (doneq[0] != 1) begin miss++; $display("FAIL single_done_idx: got %0d want 1", doneq[0]); end
    end
    vec++; if (grant_id !== 3'd1) begin miss++; $display("FAIL single_grant_id: got %0d want 1", grant_id); end
    vec++; if (busy !== 1'b0) begin miss++; $display("FAIL single_busy_idle: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    int exp_g [5];
    int k;
    bit ok;
    exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 2; exp_g[3] = 3; exp_g[4] = 0;
    do_reset();
    clear_mon();
    header_in = 32'h13121110;
    req = 4'hF;
    k = 0;
    while (ackq.size() < 5 && k < 2000) begin tick(); k++; end
    req = 4'd0;
    vec++; if (ackq.size() != 5) begin miss++; $display("FAIL b2b_acks: got %0d want 5", ackq.size()); end
    wait_done(5, 500, ok);
    vec++; if (!ok) begin miss++; $display("FAIL b2b_done_timeout: got %0d dones want 5", doneq.size()); end
    for (int i = 0; i < 5; i++) begin
      if (i < ackq.size()) begin
        vec++; if (ackq[i] != exp_g[i]) begin miss++; $display("FAIL b2b_grant%0d: got %0d want %0d", i, ackq[i], exp_g[i]); end
      end
      if (i < doneq.size()) begin
        vec++; if (doneq[i] != exp_g[i]) begin miss++; $display("FAIL b2b_done%0d: got %0d want %0d", i, doneq[i], exp_g[i]); end
      end
      if (5*i < txq.size()) begin
        vec++; if (txq[5*i] !== 8'(8'h10 + exp_g[i])) begin miss++; $display("FAIL b2b_hdr%0d: got %h want %h", i, txq[5*i], 8'(8'h10 + exp_g[i])); end
      end
    end
    vec++; if (txq.size() != 25) begin miss++; $display("FAIL b2b_nbytes: got %0d want 25", txq.size()); end
    vec++; if (overlap != 0) begin miss++; $display("FAIL b2b_overlap: got %0d want 0", overlap); end
  endtask

  task automatic test_starvation;
    int exp_g [4];
    int k;
    bit ok;
    exp_g[0] = 0; exp_g[1] = 2; exp_g[2] = 0; exp_g[3] = 2;
    do_reset();
    clear_mon();
    req = 4'b0101;
    k = 0;
    while (ackq.size() < 4 && k < 3000) begin
      tick();
      k++;
      if (ack[0])  req[0] = 1'b0;
      if (done[0]) req[0] = 1'b1;
    end
    req = 4'd0;
    wait_done(4, 500, ok);
    vec++; if (!ok) begin miss++; $display("FAIL starve_done_timeout: got %0d dones want 4", doneq.size()); end
    vec++; if (ackq.size() != 4) begin miss++; $display("FAIL starve_acks: got %0d want 4", ackq.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < ackq.size()) begin
        vec++; if (ackq[i] != exp_g[i]) begin miss++; $display("FAIL starve_grant%0d: got %0d want %0d", i, ackq[i], exp_g[i]); end
      end
    end
  endtask

  task automatic test_noaccept;
    logic [7:0] exp_b [5];
    bit ok;
    exp_b[0] = 8'h3C; exp_b[1] = 8'hEF; exp_b[2] = 8'hBE; exp_b[3] = 8'hAD; exp_b[4] = 8'hDE;
    do_reset();
    clear_mon();
    busy_dis = 1'b1;
    header_in[31:24]   = 8'h3C;
    payload_in[127:96] = 32'hDEADBEEF;
    req = 4'b1000;
    tick();
    vec++; if (ack !== 4'b1000) begin miss++; $display("FAIL noacc_ack: got %b want 1000", ack); end
    vec++; if (err_noaccept !== 1'b0) begin miss++; $display("FAIL noacc_err_early: got %b want 0", err_noaccept); end
    req = 4'd0;
    wait_done(1, 400, ok);
    vec++; if (!ok) begin miss++; $display("FAIL noacc_done_timeout: got %0d dones want 1", doneq.size()); end
    vec++; if (err_noaccept !== 1'b1) begin miss++; $display("FAIL noacc_err: got %b want 1", err_noaccept); end
    vec++; if (err_cyc - first_start != 15) begin miss++; $display("FAIL noacc_err_lat: got %0d want 15", err_cyc - first_start); end
    vec++; if (txq.size() != 5) begin miss++; $display("FAIL noacc_nbytes: got %0d want 5", txq.size()); end
    for (int i = 0; i < 5; i++) begin
      if (i < txq.size()) begin
        vec++; if (txq[i] !== exp_b[i]) begin miss++; $display("FAIL noacc_byte%0d: got %h want %h", i, txq[i], exp_b[i]); end
      end
    end
    if (doneq.size() > 0) begin
      vec++; if (doneq[0] != 3) begin miss++; $display("FAIL noacc_done_idx: got %0d want 3", doneq[0]); end
    end
    busy_dis = 1'b0;
    repeat (5) tick();
    vec++; if (err_noaccept !== 1'b1) begin miss++; $display("FAIL noacc_sticky: got %b want 1", err_noaccept); end
  endtask

  task automatic test_reset_mid;
    int k;
    bit ok;
    do_reset();
    vec++; if (err_noaccept !== 1'b0) begin miss++; $display("FAIL mid_err_cleared: got %b want 0", err_noaccept); end
    clear_mon();
    header_in[15:8]   = 8'h77;
    payload_in[63:32] = 32'h01020304;
    header_in[23:16]  = 8'h99;
    req = 4'b0010;
    tick();
    req = 4'd0;
    k = 0;
    while (!(txq.size() >= 3 && tx_busy) && k < 500) begin tick(); k++; end
    vec++; if (!(txq.size() >= 3 && tx_busy)) begin miss++; $display("FAIL mid_reach_byte3: got %0d bytes want 3", txq.size()); end
    req = 4'b0100;
    rst_n = 1'b0;
    #1;
    vec++; if (busy !== 1'b0)     begin miss++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    vec++; if (tx_start !== 1'b0) begin miss++; $display("FAIL mid_rst_tx_start: got %b want 0", tx_start); end
    vec++; if (tx_data !== 8'h00) begin miss++; $display("FAIL mid_rst_tx_data: got %h want 00", tx_data); end
    vec++; if (grant_id !== 3'd0) begin miss++; $display("FAIL mid_rst_grant_id: got %0d want 0", grant_id); end
    vec++; if (ack !== 4'd0)      begin miss++; $display("FAIL mid_rst_ack: got %b want 0", ack); end
    tick();
    rst_n = 1'b1;
    vec++; if (tx_busy !== 1'b1) begin miss++; $display("FAIL mid_busy_after_rst: got %b want 1", tx_busy); end
    k = 0;
    while (tx_busy && k < 50) begin tick(); k++; end
    vec++; if (ackq.size() != 1 || ack !== 4'd0) begin miss++; $display("FAIL mid_no_grant_while_busy: got %0d acks want 1", ackq.size()); end
    tick();
    vec++; if (ack !== 4'b0100) begin miss++; $display("FAIL mid_grant_after: got %b want 0100", ack); end
    vec++; if (grant_id !== 3'd2) begin miss++; $display("FAIL mid_grant_id: got %0d want 2", grant_id); end
    req = 4'd0;
    wait_done(1, 300, ok);
    vec++; if (!ok) begin miss++; $display("FAIL mid_done_timeout: got %0d dones want 1", doneq.size()); end
  endtask

  task automatic test_foreign_busy;
    bit ok;
    clear_mon();
    ext_busy = 1'b1;
    req = 4'b1000;
    repeat (8) tick();
    vec++; if (ackq.size() != 0) begin miss++; $display("FAIL foreign_no_ack: got %0d acks want 0", ackq.size()); end
    vec++; if (busy !== 1'b0) begin miss++; $display("FAIL foreign_idle: got %b want 0", busy); end
    ext_busy = 1'b0;
    tick();
    vec++; if (ack !== 4'b1000) begin miss++; $display("FAIL foreign_ack: got %b want 1000", ack); end
    req = 4'd0;
    wait_done(1, 300, ok);
    vec++; if (!ok) begin miss++; $display("FAIL foreign_done_timeout: got %0d dones want 1", doneq.size()); end
    if (doneq.size() > 0) begin
      vec++; if (doneq[0] != 3) begin miss++; $display("FAIL foreign_done_idx: got %0d want 3", doneq[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_starvation();
    test_noaccept();
    test_reset_mid();
    test_foreign_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
